// File: rtl/udma_sdio_pkg.sv
// Shared types and constants for the SDIO command-line engine.
// Response types, FSM states, status bit positions and frame sizes.
package udma_sdio_pkg;

  localparam logic [2:0] RSP_NONE     = 3'd0;
  localparam logic [2:0] RSP_48_CRC   = 3'd1;
  localparam logic [2:0] RSP_48_NOCRC = 3'd2;
  localparam logic [2:0] RSP_136      = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_NCC
  } state_e;

  localparam int STS_TIMEOUT = 0;
  localparam int STS_CRC     = 1;
  localparam int STS_END     = 2;
  localparam int STS_INDEX   = 3;

  localparam int FRAME_48    = 48;
  localparam int FRAME_136   = 136;
  localparam int NCC_CYCLES  = 8;
  localparam int TURNAROUND  = 2;

endpackage

// File: rtl/udma_sdio_cmd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first, zero initial value.
// Clear takes priority over a data step in the same cycle.
module sdio_crc7 (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       data_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       fb;

  always_comb begin
    fb    = data_i ^ crc_q[6];
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[5:3], crc_q[2] ^ fb,
               crc_q[1:0], fb};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/udma_sdio_cmd.sv
// SD CMD-line engine: sends a 48-bit command with CRC7, then
// optionally captures and checks a 48- or 136-bit response.
module udma_sdio_cmd
  import udma_sdio_pkg::*;
#(
  parameter int RSP_TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_op_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [2:0]   rsp_type_i,
  output logic         busy_o,
  output logic         eot_o,
  output logic [3:0]   status_o,
  output logic [127:0] rsp_data_o,
  output logic         cmd_o,
  output logic         cmd_oen_o,
  input  logic         cmd_i
);

  localparam int CNT_MAX =
    (RSP_TIMEOUT + TURNAROUND > FRAME_136) ?
    RSP_TIMEOUT + TURNAROUND : FRAME_136;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TX_CRC =
    CNT_W'(FRAME_48 - 9);
  localparam logic [CNT_W-1:0] TX_END =
    CNT_W'(FRAME_48 - 2);
  localparam logic [CNT_W-1:0] TX_LAST =
    CNT_W'(FRAME_48 - 1);
  localparam logic [CNT_W-1:0] WAIT_OPEN =
    CNT_W'(TURNAROUND);
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'(RSP_TIMEOUT + TURNAROUND - 1);
  localparam logic [CNT_W-1:0] RX48_CRC =
    CNT_W'(FRAME_48 - 10);
  localparam logic [CNT_W-1:0] RX48_LAST =
    CNT_W'(FRAME_48 - 2);
  localparam logic [CNT_W-1:0] RX136_CRC0 =
    CNT_W'(7);
  localparam logic [CNT_W-1:0] RX136_CRC =
    CNT_W'(FRAME_136 - 10);
  localparam logic [CNT_W-1:0] RX136_LAST =
    CNT_W'(FRAME_136 - 2);
  localparam logic [CNT_W-1:0] NCC_LAST =
    CNT_W'(NCC_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         op_q, op_d;
  logic [2:0]         typ_q, typ_d;
  logic [38:0]        tx_q, tx_d;
  logic [126:0]       rx_q, rx_d;
  logic [3:0]         status_q, status_d;
  logic [127:0]       rsp_q, rsp_d;
  logic               cmd_q, cmd_d;
  logic               oen_q, oen_d;
  logic               eot_q, eot_d;

  logic               crc_clr;
  logic               crc_en;
  logic               crc_data;
  logic [6:0]         crc;
  logic [CNT_W-1:0]   crc_off;
  logic [127:0]       rx_sh;
  logic               is136;
  logic [CNT_W-1:0]   rx_last;

  sdio_crc7 u_crc (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (crc_data),
    .crc_o  (crc)
  );

  assign crc_off = cnt_q - TX_CRC;
  assign rx_sh   = {rx_q, cmd_i};
  assign is136   = (typ_q == RSP_136);
  assign rx_last = is136 ? RX136_LAST : RX48_LAST;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    op_d     = op_q;
    typ_d    = typ_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    status_d = status_q;
    rsp_d    = rsp_q;
    cmd_d    = cmd_q;
    oen_d    = oen_q;
    eot_d    = 1'b0;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    crc_data = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // a start coinciding with eot belongs to the old command
        if (start_i && !eot_q) begin
          state_d  = ST_TX;
          op_d     = cmd_op_i;
          typ_d    = (rsp_type_i > RSP_136) ?
                     RSP_NONE : rsp_type_i;
          tx_d     = {1'b1, cmd_op_i, cmd_arg_i};
          status_d = '0;
          rsp_d    = '0;
          cmd_d    = 1'b0;
          oen_d    = 1'b0;
          crc_clr  = 1'b1;
        end
      end

      ST_TX: begin
        // CRC is fed with each bit as it is loaded onto the pin;
        // the leading start bit is zero so it never alters it
        if (cnt_q < TX_CRC) begin
          cmd_d    = tx_q[38];
          tx_d     = {tx_q[37:0], 1'b0};
          crc_en   = 1'b1;
          crc_data = tx_q[38];
        end else if (cnt_q < TX_END) begin
          cmd_d = crc[3'd6 - crc_off[2:0]];
        end else if (cnt_q < TX_LAST) begin
          cmd_d = 1'b1;
        end else begin
          cmd_d   = 1'b1;
          oen_d   = 1'b1;
          cnt_d   = '0;
          crc_clr = 1'b1;
          state_d = (typ_q == RSP_NONE) ?
                    ST_NCC : ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q >= WAIT_OPEN) begin
          if (!cmd_i) begin
            state_d = ST_RX;
            cnt_d   = '0;
            crc_clr = 1'b1;
          end else if (cnt_q == WAIT_LAST) begin
            status_d[STS_TIMEOUT] = 1'b1;
            state_d = ST_NCC;
            cnt_d   = '0;
          end
        end
      end

      ST_RX: begin
        rx_d     = rx_sh[126:0];
        crc_data = cmd_i;
        crc_en   = is136 ?
                   (cnt_q >= RX136_CRC0 &&
                    cnt_q <= RX136_CRC) :
                   (cnt_q <= RX48_CRC);
        if (cnt_q == rx_last) begin
          rsp_d = is136 ? rx_sh :
                  {90'b0, rx_sh[45:8]};
          if (typ_q != RSP_48_NOCRC &&
              crc != rx_sh[7:1])
            status_d[STS_CRC] = 1'b1;
          if (!cmd_i)
            status_d[STS_END] = 1'b1;
          if (typ_q == RSP_48_CRC &&
              rx_sh[45:40] != op_q)
            status_d[STS_INDEX] = 1'b1;
          state_d = ST_NCC;
          cnt_d   = '0;
        end
      end

      ST_NCC: begin
        if (cnt_q == NCC_LAST) begin
          eot_d   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        cmd_d   = 1'b1;
        oen_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      typ_q    <= RSP_NONE;
      tx_q     <= '0;
      rx_q     <= '0;
      status_q <= '0;
      rsp_q    <= '0;
      cmd_q    <= 1'b1;
      oen_q    <= 1'b1;
      eot_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      typ_q    <= typ_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      status_q <= status_d;
      rsp_q    <= rsp_d;
      cmd_q    <= cmd_d;
      oen_q    <= oen_d;
      eot_q    <= eot_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign eot_o      = eot_q;
  assign status_o   = status_q;
  assign rsp_data_o = rsp_q;
  assign cmd_o      = cmd_q;
  assign cmd_oen_o  = oen_q;

endmodule

// File: tb/tb_udma_sdio_cmd.sv
// Directed bench for udma_sdio_cmd: TX frames, response capture,
// error flags, timeout, busy-ignore and mid-command reset.
module tb_udma_sdio_cmd;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   op = '0;
  logic [31:0]  arg = '0;
  logic [2:0]   typ = '0;
  logic         busy, eot, cmd, oen;
  logic         cmd_in = 1'b1;
  logic [3:0]   status;
  logic [127:0] rsp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  udma_sdio_cmd #(.RSP_TIMEOUT(64)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .start_i    (start),
    .cmd_op_i   (op),
    .cmd_arg_i  (arg),
    .rsp_type_i (typ),
    .busy_o     (busy),
    .eot_o      (eot),
    .status_o   (status),
    .rsp_data_o (rsp),
    .cmd_o      (cmd),
    .cmd_oen_o  (oen),
    .cmd_i      (cmd_in)
  );

  function automatic logic [6:0] crc7(
    input logic [127:0] d, input int n);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] r48(
    input logic [5:0] idx, input logic [31:0] a);
    logic [39:0] d;
    d = {2'b00, idx, a};
    return {d, crc7({88'b0, d}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] r136(
    input logic [119:0] pay);
    return {2'b00, 6'h3F, pay,
            crc7({8'b0, pay}, 120), 1'b1};
  endfunction

  // Drives one command and plays the card side of the CMD line.
  task automatic run(
    input  logic [5:0]   o,
    input  logic [31:0]  a,
    input  logic [2:0]   t,
    input  int           s,
    input  int           rlen,
    input  logic [135:0] rb,
    input  int           pulse_cyc,
    input  int           stop_cyc,
    input  bit           start_at_eot,
    output logic [47:0]  txf,
    output int           eot_cyc,
    output bit           oen_bad);
    txf = '0;
    eot_cyc = -1;
    oen_bad = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op = o;
    arg = a;
    typ = t;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) op = ~o;
      if (cyc <= 48) begin
        txf[48-cyc] = cmd;
        if (oen !== 1'b0) oen_bad = 1'b1;
      end else if (oen !== 1'b1) begin
        oen_bad = 1'b1;
      end
      if (s > 0 && cyc >= s && cyc < s + rlen)
        cmd_in = rb[rlen-1-(cyc-s)];
      else
        cmd_in = 1'b1;
      if (eot === 1'b1) begin
        eot_cyc = cyc;
        start = start_at_eot;
        break;
      end
      if (cyc == stop_cyc) break;
    end
    cmd_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    tests++;
    if (eot !== 1'b0) begin
      fails++;
      $display("FAIL reset_eot got %b want 0", eot);
    end
    tests++;
    if (status !== 4'h0) begin
      fails++;
      $display("FAIL reset_status got %h want 0", status);
    end
    tests++;
    if (rsp !== 128'h0) begin
      fails++;
      $display("FAIL reset_rsp got %h want 0", rsp);
    end
    tests++;
    if (cmd !== 1'b1) begin
      fails++;
      $display("FAIL reset_cmd got %b want 1", cmd);
    end
    tests++;
    if (oen !== 1'b1) begin
      fails++;
      $display("FAIL reset_oen got %b want 1", oen);
    end
  endtask

  task automatic test_cmd0;
    logic [47:0] f;
    int e;
    bit ob;
    run(6'd0, 32'h0, 3'd0, -1, 0, '0, -1, -1, 0,
        f, e, ob);
    tests++;
    if (f !== 48'h400000000095) begin
      fails++;
      $display("FAIL cmd0_frame got %h want 400000000095", f);
    end
    tests++;
    if (e != 57) begin
      fails++;
      $display("FAIL cmd0_eot got %0d want 57", e);
    end
    tests++;
    if (status !== 4'h0) begin
      fails++;
      $display("FAIL cmd0_status got %h want 0", status);
    end
    tests++;
    if (ob) begin
      fails++;
      $display("FAIL cmd0_oen got bad want clean");
    end
    idle(3);
  endtask

  task automatic test_reserved_type;
    logic [47:0] f;
    int e;
    bit ob;
    run(6'd5, 32'h1234, 3'd5, -1, 0, '0, -1, -1, 0,
        f, e, ob);
    tests++;
    if (e != 57) begin
      fails++;
      $display("FAIL rsvd_eot got %0d want 57", e);
    end
    idle(3);
  endtask

  task automatic test_r1;
    logic [47:0] f;
    int e;
    bit ob;
    run(6'd8, 32'h1AA, 3'd1, 55, 48,
        {88'b0, r48(6'd8, 32'h1AA)}, -1, -1, 0,
        f, e, ob);
    tests++;
    if (f !== 48'h48000001AA87) begin
      fails++;
      $display("FAIL cmd8_frame got %h want 48000001AA87", f);
    end
    tests++;
    if (e != 111) begin
      fails++;
      $display("FAIL cmd8_eot got %0d want 111", e);
    end
    tests++;
    if (status !== 4'h0) begin
      fails++;
      $display("FAIL cmd8_status got %h want 0", status);
    end
    tests++;
    if (rsp !== {90'b0, 6'd8, 32'h1AA}) begin
      fails++;
      $display("FAIL cmd8_rsp got %h want 8000001aa", rsp);
    end
    idle(3);
  endtask

  task automatic test_timeout;
    logic [47:0] f;
    int e;
    bit ob;
    run(6'd8, 32'h1AA, 3'd1, -1, 0, '0, -1, -1, 0,
        f, e, ob);
    tests++;
    if (status !== 4'b0001) begin
      fails++;
      $display("FAIL tmo_status got %b want 0001", status);
    end
    tests++;
    if (e != 123) begin
      fails++;
      $display("FAIL tmo_eot got %0d want 123", e);
    end
    tests++;
    if (ob) begin
      fails++;
      $display("FAIL tmo_oen got bad want clean");
    end
    tests++;
    if (rsp !== 128'h0) begin
      fails++;
      $display("FAIL tmo_rsp got %h want 0", rsp);
    end
    idle(3);
  endtask

  task automatic test_crc_err;
    logic [47:0] f;
    logic [47:0] r;
    int e;
    bit ob;
    r = r48(6'd8, 32'h1AA);
    r[20] = ~r[20];
    run(6'd8, 32'h1AA, 3'd1, 51, 48, {88'b0, r},
        -1, -1, 0, f, e, ob);
    tests++;
    if (status !== 4'b0010) begin
      fails++;
      $display("FAIL crc_status got %b want 0010", status);
    end
    tests++;
    if (rsp !== {90'b0, 6'd8, 32'h1AA ^ 32'h1000}) begin
      fails++;
      $display("FAIL crc_rsp got %h want 8000011aa", rsp);
    end
    tests++;
    if (e != 107) begin
      fails++;
      $display("FAIL crc_eot got %0d want 107", e);
    end
    idle(3);
  endtask

  task automatic test_nocrc;
    logic [47:0] f;
    int e;
    bit ob;
    run(6'd8, 32'h1AA, 3'd2, 114, 48,
        {88'b0, 2'b00, 6'd3, 32'hCAFEF00D, 7'h7F, 1'b1},
        -1, -1, 0, f, e, ob);
    tests++;
    if (status !== 4'h0) begin
      fails++;
      $display("FAIL nocrc_status got %b want 0000", status);
    end
    tests++;
    if (e != 170) begin
      fails++;
      $display("FAIL nocrc_eot got %0d want 170", e);
    end
    tests++;
    if (rsp !== {90'b0, 6'd3, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL nocrc_rsp got %h want 3cafef00d", rsp);
    end
    idle(3);
  endtask

  task automatic test_index;
    logic [47:0] f;
    int e;
    bit ob;
    run(6'd8, 32'h1AA, 3'd1, 60, 48,
        {88'b0, r48(6'd9, 32'h1AA)}, -1, -1, 0,
        f, e, ob);
    tests++;
    if (status !== 4'b1000) begin
      fails++;
      $display("FAIL idx_status got %b want 1000", status);
    end
    tests++;
    if (rsp !== {90'b0, 6'd9, 32'h1AA}) begin
      fails++;
      $display("FAIL idx_rsp got %h want 9000001aa", rsp);
    end
    idle(3);
  endtask

  task automatic test_r2;
    logic [47:0]  f;
    logic [135:0] r;
    int e;
    bit ob;
    r = r136({32'hDEADBEEF, 32'h01234567,
              32'h89ABCDEF, 24'h5A5A5A});
    run(6'd2, 32'h0, 3'd3, 52, 136, r, -1, -1, 0,
        f, e, ob);
    tests++;
    if (status !== 4'h0) begin
      fails++;
      $display("FAIL r2_status got %b want 0000", status);
    end
    tests++;
    if (rsp !== r[127:0]) begin
      fails++;
      $display("FAIL r2_rsp got %h want %h", rsp, r[127:0]);
    end
    tests++;
    if (e != 196) begin
      fails++;
      $display("FAIL r2_eot got %0d want 196", e);
    end
    idle(3);
    r[0] = 1'b0;
    run(6'd2, 32'h0, 3'd3, 52, 136, r, -1, -1, 0,
        f, e, ob);
    tests++;
    if (status !== 4'b0100) begin
      fails++;
      $display("FAIL r2end_status got %b want 0100", status);
    end
    tests++;
    if (rsp !== r[127:0]) begin
      fails++;
      $display("FAIL r2end_rsp got %h want %h", rsp, r[127:0]);
    end
    idle(3);
  endtask

  task automatic test_busy_ignore;
    logic [47:0] f;
    int e;
    bit ob;
    run(6'd0, 32'h0, 3'd0, -1, 0, '0, 10, -1, 0,
        f, e, ob);
    tests++;
    if (f !== 48'h400000000095) begin
      fails++;
      $display("FAIL ign_frame got %h want 400000000095", f);
    end
    tests++;
    if (e != 57) begin
      fails++;
      $display("FAIL ign_eot got %0d want 57", e);
    end
    idle(3);
  endtask

  task automatic test_reset_mid;
    logic [47:0] f;
    int e;
    bit ob;
    bit seen;
    run(6'd8, 32'h1AA, 3'd1, -1, 0, '0, -1, 20, 0,
        f, e, ob);
    rstn = 1'b0;
    #1;
    tests++;
    if (oen !== 1'b1 || cmd !== 1'b1) begin
      fails++;
      $display("FAIL rst_line got oen=%b cmd=%b want 1 1",
               oen, cmd);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (eot !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rst_quiet got activity want none");
    end
    tests++;
    if (status !== 4'h0) begin
      fails++;
      $display("FAIL rst_status got %h want 0", status);
    end
  endtask

  task automatic test_back_to_back;
    logic [47:0] f;
    int e;
    bit ob;
    run(6'd0, 32'h0, 3'd0, -1, 0, '0, -1, -1, 1,
        f, e, ob);
    tests++;
    if (e != 57) begin
      fails++;
      $display("FAIL b2b_eot got %0d want 57", e);
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_busy got %b want 0", busy);
    end
    idle(2);
    tests++;
    if (busy !== 1'b0 || oen !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle got busy=%b oen=%b want 0 1",
               busy, oen);
    end
  endtask

  initial begin
    test_reset;
    test_cmd0;
    test_reserved_type;
    test_r1;
    test_timeout;
    test_crc_err;
    test_nocrc;
    test_index;
    test_r2;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udma_sdio_cmd.md
# udma_sdio_cmd

SD/SDIO command-line engine. It serialises a 48-bit command frame with CRC7 onto the CMD pin, then optionally captures a 48-bit or 136-bit response, checks it and reports status. It consumes the command op, argument, response type and start pulse from the SDIO register block. It returns response words, status and end-of-transfer to that block. It runs in the SD-clock domain: one CMD bit per clk_i cycle.

## Interface
- RSP_TIMEOUT, 64: number of cycles searched for a response start bit (NCR window).
- clk_i  in  1  SD clock; CMD is driven and sampled on the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  single-cycle command request.
- cmd_op_i  in  6  command index.
- cmd_arg_i  in  32  command argument.
- rsp_type_i  in  3  response type: 0 none; 1 48-bit with CRC check and index check; 2 48-bit with no CRC or index check; 3 136-bit with CRC; 4–7 reserved, treated as 0.
- busy_o  out  1  engine active.
- eot_o  out  1  single-cycle end of command.
- status_o  out  4  error flags: [0] timeout, [1] CRC error, [2] end-bit error, [3] index mismatch.
- rsp_data_o  out  128  captured response.
- cmd_o  out  1  CMD output value.
- cmd_oen_o  out  1  CMD output enable, active-low.
- cmd_i  in  1  CMD input, sampled.

## Operation
- Reset values: busy_o=0, eot_o=0, status_o=0, rsp_data_o=0, cmd_o=1, cmd_oen_o=1 (line released).
- States: IDLE → TX → (WAIT → RX →) NCC → IDLE.
- **IDLE**
  - start_i is accepted only in IDLE; it is ignored while busy_o=1.
  - On acceptance: latch op, arg and type; clear status_o and rsp_data_o.
- **TX** (48 cycles)
  - Frame sent MSB first: 0, 1, op[5:0], arg[31:0], CRC7[6:0], 1.
  - CRC7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
  - cmd_oen_o=0 throughout TX.
  - After the end bit: cmd_oen_o=1 and cmd_o=1. Type 0 goes to NCC.
- **WAIT**
  - The first 2 cycles are turnaround; cmd_i is ignored.
  - cmd_i is then sampled for up to RSP_TIMEOUT cycles.
  - First cmd_i=0 is the start bit → RX.
  - No start bit in the window → status[0]=1 → NCC.
- **RX**
  - Receives the remaining 47 bits (types 1/2) or 135 bits (type 3) into a shift register.
  - 48-bit response: rsp_data_o[37:32]=bits[45:40] (index), rsp_data_o[31:0]=bits[39:8], rsp_data_o[127:38]=0.
  - 136-bit response: rsp_data_o=bits[127:0], with bit 0 = end bit.
  - CRC is computed over bits[46:8] (48-bit) or bits[127:8] (136-bit) and compared with the received CRC7.
    - Mismatch → status[1]. Not checked for type 2.
  - End bit ≠1 → status[2].
  - Type 1 with received index ≠ op → status[3].
  - Errors never suppress rsp_data_o.
- **NCC**
  - 8 idle cycles with the line released.
  - Then eot_o=1 for one cycle, busy_o=0, return to IDLE.
- status_o and rsp_data_o hold until the next accepted start_i.

## Timing
- start_i is sampled in cycle 0.
- busy_o is high from cycle 1 up to and including the cycle before eot_o.
- Frame bit 47 (start bit) is on cmd_o in cycle 1; bit 0 is on cmd_o in cycle 48.
- Type 0: NCC occupies cycles 49–56; eot_o=1 and busy_o=0 in cycle 57.
- Response types: cycles 49–50 are turnaround; start-bit search covers cycles 51 to 50+RSP_TIMEOUT.
- Start bit seen in cycle s: the last response bit is sampled in cycle s+47 (or s+135); NCC follows for 8 cycles; eot_o comes in the next cycle.
- Timeout: NCC occupies cycles 51+RSP_TIMEOUT to 58+RSP_TIMEOUT; eot_o is in cycle 59+RSP_TIMEOUT.
- A start bit in the last search cycle is valid and is not a timeout.
- start_i in the same cycle as eot_o is ignored.
- Reset mid-operation immediately forces the reset values and state IDLE; no partial frame completes.

## Structure
- udma_sdio_pkg holds:
  - rsp_type localparams (RSP_NONE, RSP_48_CRC, RSP_48_NOCRC, RSP_136);
  - the state enum;
  - status bit index constants;
  - frame length constants 48 and 136.
- One sub-module, sdio_crc7: serial CRC7 with clr, en, data inputs and crc[6:0] output.
  - A single instance is shared between TX and RX (they never overlap) and is cleared on state entry.
- A single cycle counter, sized for max(136, RSP_TIMEOUT+2), is reused across states.

## Test plan
- CMD0, arg 0, type 0 → cmd_o carries 0x400000000095 in cycles 1–48; eot_o in cycle 57; status_o=0.
- CMD8, arg 0x1AA, type 1 → TX frame 0x48000001AA87. Model replies with index 8, payload 0x000001AA and a correct CRC → rsp_data_o[37:0]={6'd8,32'h1AA}; status_o=0.
- Type 1, no reply, RSP_TIMEOUT=64 → status_o=4'b0001; eot_o in cycle 123; cmd_oen_o stays 1 after cycle 48.
- Type 1 reply with one payload bit flipped → status_o[1]=1 with rsp_data_o updated. Type 2 reply with CRC field 7'h7F → status_o=0. Type 1 reply with index 9 for CMD8 → status_o[3]=1.
- Type 3 reply of 136 bits with a correct CRC over bits[127:8] → rsp_data_o equals bits[127:0]; status_o=0. Same reply with end bit 0 → status_o[2]=1.
- start_i pulsed in cycle 10 while busy is ignored, with the frame unchanged. rstn_i asserted in cycle 20 → cmd_oen_o=1, cmd_o=1 and busy_o=0 immediately; no eot_o is produced.
